dma_mem2mem_ctrl: RTL and testbench

- Sequencer for memory-to-memory DMA through the 8-bit temporary data register.
- Per word: reads from the source address and latches into the temporary register (tmp_dir=1), then switches the register to drive (tmp_dir=0) and writes to the destination address.
- Bus ownership uses an 8237-style hrq/hlda handshake; terminal count is signalled on eop.
- Sits between the CPU-side configuration registers and the system address/control bus.

---
 rtl/dma_pkg.sv | 22 ++
 rtl/dma_chan_regs.sv | 54 +++++
 rtl/dma_mem2mem_ctrl.sv | 155 +++++++++++++++
 tb/tb_dma_mem2mem_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the memory-to-memory DMA sequencer.
package dma_pkg;

    localparam int unsigned DMA_ADDR_W = 16;
    localparam int unsigned DMA_CNT_W  = 16;
    localparam int unsigned DMA_WAIT_W = 4;

    // Temporary data register direction: capture from bus or drive onto bus
    localparam logic TMP_CAPTURE = 1'b1;
    localparam logic TMP_DRIVE   = 1'b0;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        RD   = 3'd2,
        XFER = 3'd3,
        WR   = 3'd4,
        UPD  = 3'd5,
        DONE = 3'd6
    } dma_state_e;

endpackage

// File: rtl/dma_chan_regs.sv
// Channel working registers: current source, destination and remaining count.
// The source-hold flag is captured with the rest of the configuration.
module dma_chan_regs
    import dma_pkg::*;
#(
    parameter int unsigned ADDR_W = DMA_ADDR_W,
    parameter int unsigned CNT_W  = DMA_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic              i_step,
    input  logic              i_src_hold,
    input  logic [ADDR_W-1:0] i_src,
    input  logic [ADDR_W-1:0] i_dst,
    input  logic [CNT_W-1:0]  i_cnt,
    output logic [ADDR_W-1:0] o_cur_src,
    output logic [ADDR_W-1:0] o_cur_dst,
    output logic              o_tc
);

    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_src_hold;

    // Load on start, advance addresses and count down once per word
    always_ff @(posedge clk) begin
        if (reset) begin
            r_src      <= '0;
            r_dst      <= '0;
            r_cnt      <= '0;
            r_src_hold <= 1'b0;
        end else if (i_load) begin
            r_src      <= i_src;
            r_dst      <= i_dst;
            r_cnt      <= i_cnt;
            r_src_hold <= i_src_hold;
        end else if (i_step) begin
            if (!r_src_hold) begin
                r_src <= r_src + ADDR_W'(1);
            end
            r_dst <= r_dst + ADDR_W'(1);
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    assign o_cur_src = r_src;
    assign o_cur_dst = r_dst;
    assign o_tc      = (r_cnt == '0);

endmodule

// File: rtl/dma_mem2mem_ctrl.sv
// Memory-to-memory DMA sequencer: read word into the temporary register,
// turn it around, write it out, with 8237-style hrq/hlda bus ownership.
// Optional macro DMA_SRC_HOLD_EN adds src_hold (fixed source address fill).
module dma_mem2mem_ctrl
    import dma_pkg::*;
#(
    parameter int unsigned ADDR_W   = DMA_ADDR_W,
    parameter int unsigned CNT_W    = DMA_CNT_W,
    parameter int unsigned WAIT_CYC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [CNT_W-1:0]  word_count,
`ifdef DMA_SRC_HOLD_EN
    input  logic              src_hold,
`endif
    input  logic              hlda,
    output logic              hrq,
    output logic [ADDR_W-1:0] addr,
    output logic              memr_n,
    output logic              memw_n,
    output logic              tmp_dir,
    output logic              busy,
    output logic              eop
);

    localparam logic [DMA_WAIT_W-1:0] WAIT_LAST = DMA_WAIT_W'(WAIT_CYC);

    dma_state_e            r_state;
    dma_state_e            w_state_next;
    logic [DMA_WAIT_W-1:0] r_wait;
    logic                  w_wait_done;
    logic                  w_load;
    logic                  w_step;
    logic                  w_src_hold;
    logic [ADDR_W-1:0]     w_cur_src;
    logic [ADDR_W-1:0]     w_cur_dst;
    logic                  w_tc;

`ifdef DMA_SRC_HOLD_EN
    assign w_src_hold = src_hold;
`else
    assign w_src_hold = 1'b0;
`endif

    assign w_load      = (r_state == IDLE) && start;
    assign w_step      = (r_state == UPD);
    assign w_wait_done = (r_wait == WAIT_LAST);

    dma_chan_regs #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_chan_regs (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_src_hold (w_src_hold),
        .i_src      (src_addr),
        .i_dst      (dst_addr),
        .i_cnt      (word_count),
        .o_cur_src  (w_cur_src),
        .o_cur_dst  (w_cur_dst),
        .o_tc       (w_tc)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Strobe stretch counter, runs only while a read or write strobe is active
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait <= '0;
        end else if (((r_state == RD) || (r_state == WR)) && !w_wait_done) begin
            r_wait <= r_wait + DMA_WAIT_W'(1);
        end else begin
            r_wait <= '0;
        end
    end

    // Next-state logic; hlda only matters when entering a new word
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (start) w_state_next = REQ;
            REQ:  if (hlda) w_state_next = RD;
            RD:   if (w_wait_done) w_state_next = XFER;
            XFER: w_state_next = WR;
            WR:   if (w_wait_done) w_state_next = UPD;
            UPD: begin
                if (w_tc) begin
                    w_state_next = DONE;
                end else if (hlda) begin
                    w_state_next = RD;
                end else begin
                    w_state_next = REQ;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Output decode from registered state and channel registers only
    always_comb begin
        hrq     = 1'b0;
        addr    = '0;
        memr_n  = 1'b1;
        memw_n  = 1'b1;
        tmp_dir = TMP_CAPTURE;
        busy    = 1'b0;
        eop     = 1'b0;
        case (r_state)
            REQ: begin
                hrq  = 1'b1;
                busy = 1'b1;
            end
            RD: begin
                hrq    = 1'b1;
                busy   = 1'b1;
                addr   = w_cur_src;
                memr_n = 1'b0;
            end
            XFER: begin
                hrq     = 1'b1;
                busy    = 1'b1;
                addr    = w_cur_dst;
                tmp_dir = TMP_DRIVE;
            end
            WR: begin
                hrq     = 1'b1;
                busy    = 1'b1;
                addr    = w_cur_dst;
                memw_n  = 1'b0;
                tmp_dir = TMP_DRIVE;
            end
            UPD: begin
                hrq  = 1'b1;
                busy = 1'b1;
            end
            DONE: eop = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dma_mem2mem_ctrl.sv
// Bench for dma_mem2mem_ctrl: two instances (WAIT_CYC=0 and 2) against a byte
// memory model and a scoreboard of expected read addresses and written words.
module tb_dma_mem2mem_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start0 = 1'b0;
    logic        start2 = 1'b0;
    logic        hlda = 1'b1;
    logic [15:0] src_addr = '0;
    logic [15:0] dst_addr = '0;
    logic [15:0] word_count = '0;
`ifdef DMA_SRC_HOLD_EN
    logic        src_hold = 1'b0;
`endif

    logic        hrq0, memr0, memw0, tdir0, busy0, eop0;
    logic        hrq2, memr2, memw2, tdir2, busy2, eop2;
    logic [15:0] addr0, addr2;

    always #5 clk = ~clk;

    dma_mem2mem_ctrl #(.ADDR_W(16), .CNT_W(16), .WAIT_CYC(0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0),
        .src_addr(src_addr), .dst_addr(dst_addr), .word_count(word_count),
`ifdef DMA_SRC_HOLD_EN
        .src_hold(src_hold),
`endif
        .hlda(hlda), .hrq(hrq0), .addr(addr0), .memr_n(memr0), .memw_n(memw0),
        .tmp_dir(tdir0), .busy(busy0), .eop(eop0)
    );

    dma_mem2mem_ctrl #(.ADDR_W(16), .CNT_W(16), .WAIT_CYC(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2),
        .src_addr(src_addr), .dst_addr(dst_addr), .word_count(word_count),
`ifdef DMA_SRC_HOLD_EN
        .src_hold(src_hold),
`endif
        .hlda(hlda), .hrq(hrq2), .addr(addr2), .memr_n(memr2), .memw_n(memw2),
        .tmp_dir(tdir2), .busy(busy2), .eop(eop2)
    );

    // Observed instance select
    bit          sel = 1'b0;
    int          wait_c = 0;
    logic        m_hrq, m_memr_n, m_memw_n, m_tmp_dir, m_busy, m_eop;
    logic [15:0] m_addr;

    always_comb begin
        if (sel) begin
            m_hrq = hrq2; m_memr_n = memr2; m_memw_n = memw2;
            m_tmp_dir = tdir2; m_busy = busy2; m_eop = eop2; m_addr = addr2;
        end else begin
            m_hrq = hrq0; m_memr_n = memr0; m_memw_n = memw0;
            m_tmp_dir = tdir0; m_busy = busy0; m_eop = eop0; m_addr = addr0;
        end
    end

    // Memory model, temporary register model and scoreboard
    logic [7:0]  mem [0:65535];
    logic [7:0]  tmp = '0;
    logic [15:0] exp_rd [$];
    logic [15:0] exp_wa [$];
    logic [7:0]  exp_wd [$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc, first_rd, rd_start, xfer_cyc, eop_cyc, eop_cnt;
    int rd_len, wr_len, rd_cnt, wr_cnt;

    task automatic sb_clear();
        exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
        cyc = -1; first_rd = -1; rd_start = -1; xfer_cyc = -100; eop_cyc = -1;
        eop_cnt = 0; rd_len = 0; wr_len = 0; rd_cnt = 0; wr_cnt = 0;
    endtask

    task automatic push_expect(input logic [15:0] sa, input logic [15:0] da,
                               input logic [15:0] wc, input bit hold);
        logic [15:0] s;
        for (int i = 0; i <= int'(wc); i++) begin
            s = hold ? sa : sa + 16'(i);
            exp_rd.push_back(s);
            exp_wa.push_back(da + 16'(i));
            exp_wd.push_back(mem[s]);
        end
    endtask

    // One clock of bus observation: scoreboard pops plus strobe protocol checks
    task automatic sb_cycle();
        logic [15:0] ea;
        logic [7:0]  ed;
        @(negedge clk);
        cyc++;
        if (m_memr_n === 1'b0) begin
            if (rd_len == 0) begin
                rd_cnt++;
                rd_start = cyc;
                if (first_rd < 0) first_rd = cyc;
                n_checks++;
                if (exp_rd.size() == 0) begin
                    n_fail++; $display("FAIL rd_unexpected addr=%h", m_addr);
                end else begin
                    ea = exp_rd.pop_front();
                    if (m_addr !== ea) begin
                        n_fail++; $display("FAIL rd_addr got=%h exp=%h", m_addr, ea);
                    end
                end
            end
            rd_len++;
            n_checks++;
            if (m_memw_n !== 1'b1 || m_tmp_dir !== 1'b1 || m_hrq !== 1'b1) begin
                n_fail++;
                $display("FAIL rd_ctl memw_n=%b tmp_dir=%b hrq=%b exp 1 1 1", m_memw_n, m_tmp_dir, m_hrq);
            end
            tmp = mem[m_addr];
        end else if (rd_len > 0) begin
            n_checks++;
            if (rd_len != wait_c + 1) begin
                n_fail++; $display("FAIL rd_len got=%0d exp=%0d", rd_len, wait_c + 1);
            end
            n_checks++;
            if (m_tmp_dir !== 1'b0 || m_memw_n !== 1'b1 ||
                (exp_wa.size() != 0 && m_addr !== exp_wa[0])) begin
                n_fail++;
                $display("FAIL xfer tmp_dir=%b memw_n=%b addr=%h exp 0 1 %h", m_tmp_dir, m_memw_n, m_addr,
                         (exp_wa.size() != 0) ? exp_wa[0] : 16'h0);
            end
            xfer_cyc = cyc;
            rd_len = 0;
        end
        if (m_memw_n === 1'b0) begin
            if (wr_len == 0) begin
                wr_cnt++;
                n_checks++;
                if (exp_wa.size() == 0) begin
                    n_fail++; $display("FAIL wr_unexpected addr=%h", m_addr);
                end else begin
                    ea = exp_wa.pop_front();
                    ed = exp_wd.pop_front();
                    if (m_addr !== ea || tmp !== ed || cyc != xfer_cyc + 1) begin
                        n_fail++;
                        $display("FAIL wr_word addr=%h data=%h cyc=%0d exp addr=%h data=%h cyc=%0d",
                                 m_addr, tmp, cyc, ea, ed, xfer_cyc + 1);
                    end
                end
                mem[m_addr] = tmp;
            end
            wr_len++;
            n_checks++;
            if (m_tmp_dir !== 1'b0 || m_memr_n !== 1'b1 || m_hrq !== 1'b1) begin
                n_fail++;
                $display("FAIL wr_ctl tmp_dir=%b memr_n=%b hrq=%b exp 0 1 1", m_tmp_dir, m_memr_n, m_hrq);
            end
        end else if (wr_len > 0) begin
            n_checks++;
            if (wr_len != wait_c + 1 || m_tmp_dir !== 1'b1) begin
                n_fail++;
                $display("FAIL wr_len got=%0d tmp_dir=%b exp=%0d 1", wr_len, m_tmp_dir, wait_c + 1);
            end
            wr_len = 0;
        end
        if (m_eop === 1'b1) begin
            eop_cnt++;
            eop_cyc = cyc;
            n_checks++;
            if (m_hrq !== 1'b0 || m_busy !== 1'b0) begin
                n_fail++; $display("FAIL done_ctl hrq=%b busy=%b exp 0 0", m_hrq, m_busy);
            end
        end
    endtask

    // Pulse start on the selected instance; the cycle it samples is REQ (cyc 0)
    task automatic kick(input bit s, input logic [15:0] sa, input logic [15:0] da,
                        input logic [15:0] wc);
        sel = s;
        wait_c = s ? 2 : 0;
        src_addr = sa; dst_addr = da; word_count = wc;
        if (s) start2 = 1'b1; else start0 = 1'b1;
        sb_cycle();
        start0 = 1'b0; start2 = 1'b0;
    endtask

    task automatic wait_eop(output bit timed_out);
        for (int k = 0; k < 400 && eop_cnt == 0; k++) sb_cycle();
        timed_out = (eop_cnt == 0);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = bit'(s);
            #1;
            n_checks++;
            if ({m_hrq, m_memr_n, m_memw_n, m_tmp_dir, m_busy, m_eop} !== 6'b011100) begin
                n_fail++;
                $display("FAIL reset_ctl dut=%0d got=%b exp=011100", s,
                         {m_hrq, m_memr_n, m_memw_n, m_tmp_dir, m_busy, m_eop});
            end
            n_checks++;
            if (m_addr !== 16'h0) begin
                n_fail++; $display("FAIL reset_addr dut=%0d got=%h exp=0000", s, m_addr);
            end
        end
        sel = 1'b0;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wr();
        for (int i = 0; i < 4; i++) mem[16'h0020 + 16'(i)] = 8'(8'hA0 + i);
        sb_clear();
        push_expect(16'h0020, 16'h0600, 16'd3, 1'b0);
        kick(1'b0, 16'h0020, 16'h0600, 16'd3);
        for (int k = 0; k < 100 && wr_cnt == 0; k++) sb_cycle();
        n_checks++;
        if (wr_cnt == 0) begin n_fail++; $display("FAIL rstwr_timeout wr_cnt=0 exp>0"); end
        reset = 1'b1;
        sb_cycle();
        n_checks++;
        if ({m_hrq, m_memr_n, m_memw_n, m_tmp_dir, m_busy, m_eop} !== 6'b011100) begin
            n_fail++;
            $display("FAIL rstwr_ctl got=%b exp=011100", {m_hrq, m_memr_n, m_memw_n, m_tmp_dir, m_busy, m_eop});
        end
        sb_cycle();
        reset = 1'b0;
        sb_cycle();
        sb_cycle();
        n_checks++;
        if (eop_cnt != 0 || m_busy !== 1'b0) begin
            n_fail++; $display("FAIL rstwr_abort eop_cnt=%0d busy=%b exp 0 0", eop_cnt, m_busy);
        end
    endtask

    task automatic test_single();
        bit to;
        mem[16'h0010] = 8'hAF;
        mem[16'h0200] = 8'h00;
        sb_clear();
        push_expect(16'h0010, 16'h0200, 16'd0, 1'b0);
        kick(1'b0, 16'h0010, 16'h0200, 16'd0);
        wait_eop(to);
        n_checks++;
        if (to || first_rd != 1 || eop_cyc - first_rd != 4) begin
            n_fail++;
            $display("FAIL single_seq timeout=%0b first_rd=%0d span=%0d exp 0 1 4", to, first_rd, eop_cyc - first_rd);
        end
        sb_cycle();
        n_checks++;
        if (m_eop !== 1'b0 || m_busy !== 1'b0 || m_hrq !== 1'b0 || eop_cnt != 1) begin
            n_fail++;
            $display("FAIL single_eop eop=%b busy=%b hrq=%b eop_cnt=%0d exp 0 0 0 1", m_eop, m_busy, m_hrq, eop_cnt);
        end
        n_checks++;
        if (mem[16'h0200] !== 8'hAF || rd_cnt != 1 || wr_cnt != 1) begin
            n_fail++;
            $display("FAIL single_mem got=%h rd=%0d wr=%0d exp af 1 1", mem[16'h0200], rd_cnt, wr_cnt);
        end
    endtask

    task automatic test_block4();
        bit to;
        for (int i = 0; i < 4; i++) mem[16'h0100 + 16'(i)] = 8'($urandom_range(255));
        sb_clear();
        push_expect(16'h0100, 16'h0300, 16'd3, 1'b0);
        kick(1'b0, 16'h0100, 16'h0300, 16'd3);
        wait_eop(to);
        n_checks++;
        if (to || eop_cyc - first_rd != 16) begin
            n_fail++; $display("FAIL block4_span timeout=%0b span=%0d exp 0 16", to, eop_cyc - first_rd);
        end
        sb_cycle();
        n_checks++;
        if (m_eop !== 1'b0 || eop_cnt != 1 || wr_cnt != 4 || exp_wa.size() != 0) begin
            n_fail++;
            $display("FAIL block4_end eop=%b eop_cnt=%0d wr=%0d left=%0d exp 0 1 4 0", m_eop, eop_cnt, wr_cnt, exp_wa.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (mem[16'h0300 + 16'(i)] !== mem[16'h0100 + 16'(i)]) begin
                n_fail++;
                $display("FAIL block4_mem idx=%0d got=%h exp=%h", i, mem[16'h0300 + 16'(i)], mem[16'h0100 + 16'(i)]);
            end
        end
    endtask

    task automatic test_hlda_drop();
        bit dropped = 1'b0;
        int low_n = 0;
        int up_cyc = -1;
        for (int i = 0; i < 3; i++) mem[16'h0800 + 16'(i)] = 8'(8'h61 + i);
        sb_clear();
        push_expect(16'h0800, 16'h0900, 16'd2, 1'b0);
        kick(1'b0, 16'h0800, 16'h0900, 16'd2);
        for (int k = 0; k < 400 && eop_cnt == 0; k++) begin
            sb_cycle();
            if (dropped && hlda == 1'b0) begin
                n_checks++;
                if (m_hrq !== 1'b1 || m_busy !== 1'b1 || m_memr_n !== 1'b1 || m_memw_n !== 1'b1) begin
                    n_fail++;
                    $display("FAIL drop_hold hrq=%b busy=%b memr_n=%b memw_n=%b exp 1 1 1 1",
                             m_hrq, m_busy, m_memr_n, m_memw_n);
                end
                low_n++;
                if (low_n == 5) begin hlda = 1'b1; up_cyc = cyc; end
            end
            if (!dropped && wr_cnt == 2) begin hlda = 1'b0; dropped = 1'b1; end
        end
        hlda = 1'b1;
        n_checks++;
        if (eop_cnt != 1 || rd_cnt != 3 || wr_cnt != 3 || exp_wa.size() != 0) begin
            n_fail++;
            $display("FAIL drop_words eop=%0d rd=%0d wr=%0d left=%0d exp 1 3 3 0", eop_cnt, rd_cnt, wr_cnt, exp_wa.size());
        end
        n_checks++;
        if (up_cyc < 0 || rd_start != up_cyc + 1) begin
            n_fail++; $display("FAIL drop_resume rd_start=%0d exp=%0d", rd_start, up_cyc + 1);
        end
        sb_cycle();
    endtask

    task automatic test_wrap_wait();
        mem[16'hFFFF] = 8'h3C;
        mem[16'h0000] = 8'hC3;
        sb_clear();
        push_expect(16'hFFFF, 16'h7FFF, 16'd1, 1'b0);
        kick(1'b1, 16'hFFFF, 16'h7FFF, 16'd1);
        for (int k = 0; k < 400 && eop_cnt == 0; k++) begin
            sb_cycle();
            if (cyc == 5) begin
                start2 = 1'b1; src_addr = 16'h1234; dst_addr = 16'h4444; word_count = 16'd9;
            end else begin
                start2 = 1'b0;
            end
        end
        start2 = 1'b0;
        n_checks++;
        if (eop_cnt != 1 || first_rd != 1 || eop_cyc - first_rd != 16) begin
            n_fail++;
            $display("FAIL wrap_span eop=%0d first_rd=%0d span=%0d exp 1 1 16", eop_cnt, first_rd, eop_cyc - first_rd);
        end
        sb_cycle();
        sb_cycle();
        n_checks++;
        if (mem[16'h7FFF] !== 8'h3C || mem[16'h8000] !== 8'hC3 || m_busy !== 1'b0 || wr_cnt != 2) begin
            n_fail++;
            $display("FAIL wrap_mem got=%h %h busy=%b wr=%0d exp 3c c3 0 2",
                     mem[16'h7FFF], mem[16'h8000], m_busy, wr_cnt);
        end
    endtask

`ifdef DMA_SRC_HOLD_EN
    task automatic test_src_hold();
        bit to;
        mem[16'h0040] = 8'h55;
        mem[16'h0041] = 8'hEE;
        for (int i = 0; i < 8; i++) mem[16'h0500 + 16'(i)] = 8'h00;
        sb_clear();
        push_expect(16'h0040, 16'h0500, 16'd7, 1'b1);
        src_hold = 1'b1;
        kick(1'b0, 16'h0040, 16'h0500, 16'd7);
        src_hold = 1'b0;
        wait_eop(to);
        n_checks++;
        if (to || eop_cyc - first_rd != 32 || rd_cnt != 8) begin
            n_fail++; $display("FAIL hold_span timeout=%0b span=%0d rd=%0d exp 0 32 8", to, eop_cyc - first_rd, rd_cnt);
        end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (mem[16'h0500 + 16'(i)] !== 8'h55) begin
                n_fail++; $display("FAIL hold_mem idx=%0d got=%h exp=55", i, mem[16'h0500 + 16'(i)]);
            end
        end
        sb_cycle();
    endtask
`endif

    initial begin
        sb_clear();
        test_reset();
        test_reset_mid_wr();
        test_single();
        test_block4();
        test_hlda_drop();
        test_wrap_wait();
`ifdef DMA_SRC_HOLD_EN
        test_src_hold();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
